// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - shared enums and field widths for the hash table pipeline
package hash_table_pkg;

  localparam int OP_WIDTH     = 2;
  localparam int STATUS_WIDTH = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  typedef enum logic [STATUS_WIDTH-1:0] {
    ST_NONE = 2'b00,
    ST_OK   = 2'b01,
    ST_MISS = 2'b10,
    ST_COLL = 2'b11
  } status_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/hash_xor_fold.sv
// rtl/hash_xor_fold.sv - XOR-folds a key into an ADDR_WIDTH-bit table index
module hash_xor_fold #(
  parameter int KEY_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [KEY_WIDTH-1:0]  key,
  output logic [ADDR_WIDTH-1:0] index
);

  // Key bit i lands on index bit i mod ADDR_WIDTH, which zero-extends the last partial chunk.
  always_comb begin
    index = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      index[i % ADDR_WIDTH] = index[i % ADDR_WIDTH] ^ key[i];
    end
  end

endmodule

// File: rtl/hash_table_pipe.sv
// rtl/hash_table_pipe.sv - direct-mapped key/value store behind a 2-stage stream pipeline
// Optional: HASH_TABLE_PIPE_STATS_EN enables the occupancy counter on occupancy_o.
module hash_table_pipe
  import hash_table_pkg::*;
#(
  parameter  int KEY_WIDTH   = 8,
  parameter  int VALUE_WIDTH = 22,
  parameter  int ADDR_WIDTH  = 4,
  localparam int DATA_WIDTH  = OP_WIDTH + KEY_WIDTH + VALUE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic [ADDR_WIDTH:0]   occupancy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_e                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic                    adv;

  op_e                     in_op;
  logic [KEY_WIDTH-1:0]    in_key;
  logic [VALUE_WIDTH-1:0]  in_value;
  logic [ADDR_WIDTH-1:0]   in_idx;

  op_e                     s0_op;
  logic [KEY_WIDTH-1:0]    s0_key;
  logic [VALUE_WIDTH-1:0]  s0_value;
  logic [ADDR_WIDTH-1:0]   s0_idx;
  logic                    s0_vld;
  logic                    s0_last;

  logic [DEPTH-1:0]        tbl_vld;
  logic [KEY_WIDTH-1:0]    tbl_key [DEPTH];
  logic [VALUE_WIDTH-1:0]  tbl_val [DEPTH];

  logic                    ent_vld;
  logic                    hit;
  status_e                 res_status;
  logic [VALUE_WIDTH-1:0]  res_value;
  logic                    wr_en;
  logic                    del_en;
  logic                    commit;
  logic                    clr_done;

  assign in_op    = op_e'(data_in[DATA_WIDTH-1 -: OP_WIDTH]);
  assign in_key   = data_in[VALUE_WIDTH +: KEY_WIDTH];
  assign in_value = data_in[VALUE_WIDTH-1:0];

  hash_xor_fold #(
    .KEY_WIDTH  (KEY_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hash (
    .key   (in_key),
    .index (in_idx)
  );

  assign clr_done = (state == S_CLEAR) && (clr_ptr == '1);

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    ready_o   = 1'b0;
    case (state)
      S_RUN: begin
        ready_o = ready_i;
        adv     = ready_i;
        if (flush_i) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_ptr == '1) state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_RUN;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= (state == S_RUN) ? '0 : clr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_op    <= OP_NOP;
      s0_key   <= '0;
      s0_value <= '0;
      s0_idx   <= '0;
      s0_vld   <= 1'b0;
      s0_last  <= 1'b0;
    end else if (adv) begin
      s0_op    <= valid_i ? in_op : OP_NOP;
      s0_key   <= in_key;
      s0_value <= in_value;
      s0_idx   <= in_idx;
      s0_vld   <= valid_i;
      s0_last  <= last_i && valid_i;
    end
  end

  // Lookup and update share S1, so back-to-back beats on one index need no forwarding.
  assign ent_vld = tbl_vld[s0_idx];
  assign hit     = ent_vld && (tbl_key[s0_idx] == s0_key);
  assign commit  = adv && s0_vld;

  always_comb begin
    res_status = ST_NONE;
    res_value  = s0_value;
    wr_en      = 1'b0;
    del_en     = 1'b0;
    case (s0_op)
      OP_NOP: ;
      OP_READ: begin
        res_status = hit ? ST_OK : ST_MISS;
        res_value  = hit ? tbl_val[s0_idx] : '0;
      end
      OP_WRITE: begin
        if (!ent_vld || hit) begin
          res_status = ST_OK;
          wr_en      = 1'b1;
        end else begin
          res_status = ST_COLL;
          res_value  = tbl_val[s0_idx];
        end
      end
      OP_DELETE: begin
        res_status = hit ? ST_OK : ST_MISS;
        res_value  = hit ? tbl_val[s0_idx] : '0;
        del_en     = hit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_vld <= '0;
    end else if (state == S_CLEAR) begin
      tbl_vld[clr_ptr] <= 1'b0;
    end else if (commit && wr_en) begin
      tbl_vld[s0_idx] <= 1'b1;
    end else if (commit && del_en) begin
      tbl_vld[s0_idx] <= 1'b0;
    end
  end

  // Key/value storage needs no reset; the vld bits gate every use of it.
  always_ff @(posedge clk) begin
    if (commit && wr_en) begin
      tbl_key[s0_idx] <= s0_key;
      tbl_val[s0_idx] <= s0_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      read_data_o <= '0;
    end else if (adv) begin
      valid_o     <= s0_vld;
      last_o      <= s0_last;
      read_data_o <= s0_vld ? {res_status, s0_key, res_value} : '0;
    end
  end

`ifdef HASH_TABLE_PIPE_STATS_EN
  localparam logic [ADDR_WIDTH:0] OCC_MAX = (ADDR_WIDTH+1)'(DEPTH);
  logic [ADDR_WIDTH:0] occ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ <= '0;
    end else if (clr_done) begin
      occ <= '0;
    end else if (commit && wr_en && !ent_vld && occ != OCC_MAX) begin
      occ <= occ + 1'b1;
    end else if (commit && del_en && occ != '0) begin
      occ <= occ - 1'b1;
    end
  end

  assign occupancy_o = occ;
`else
  assign occupancy_o = '0;
`endif

endmodule

// File: tb/tb_hash_table_pipe.sv
// tb/tb_hash_table_pipe.sv - randomized bench with a table-level reference model for hash_table_pipe
module tb_hash_table_pipe;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_i, last_i, ready_i, flush_i;
  logic        ready_o, valid_o, last_o;
  logic [31:0] read_data_o;
  logic [4:0]  occupancy_o;

  always #5 clk = ~clk;

  hash_table_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .ready_i     (ready_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .read_data_o (read_data_o),
    .occupancy_o (occupancy_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          v;
    bit          last;
    logic [1:0]  op;
    logic [7:0]  key;
    logic [21:0] val;
  } beat_t;

  bit          m_vld [DEPTH];
  logic [7:0]  m_key [DEPTH];
  logic [21:0] m_val [DEPTH];
  beat_t       m_mid;
  bit          o_v, o_last;
  logic [31:0] o_data;
  int          clear_left;
  int          occ_frozen;
  logic [31:0] got_q [$];

  function automatic int fold(input int key);
    int idx = 0;
    while (key > 0) begin
      idx = idx ^ (key % 16);
      key = key / 16;
    end
    return idx;
  endfunction

  function automatic logic [31:0] pack(input logic [1:0] st, input logic [7:0] key, input logic [21:0] val);
    return {st, key, val};
  endfunction

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_vld[i] ? 1 : 0;
    return n;
  endfunction

  task automatic exec(input beat_t b);
    int          idx;
    bit          hit;
    logic [1:0]  st;
    logic [21:0] v;
    o_v    = b.v;
    o_last = b.v && b.last;
    if (!b.v) begin
      o_data = '0;
      return;
    end
    idx = fold(int'(b.key));
    hit = m_vld[idx] && (m_key[idx] == b.key);
    st  = 2'd0;
    v   = b.val;
    case (b.op)
      2'd1: begin st = hit ? 2'd1 : 2'd2; v = hit ? m_val[idx] : '0; end
      2'd2: begin
        if (!m_vld[idx] || hit) begin
          st = 2'd1; m_vld[idx] = 1'b1; m_key[idx] = b.key; m_val[idx] = b.val;
        end else begin
          st = 2'd3; v = m_val[idx];
        end
      end
      2'd3: begin
        st = hit ? 2'd1 : 2'd2;
        v  = hit ? m_val[idx] : '0;
        if (hit) m_vld[idx] = 1'b0;
      end
      default: ;
    endcase
    o_data = pack(st, b.key, v);
  endtask

  function automatic logic [4:0] exp_occ();
`ifdef HASH_TABLE_PIPE_STATS_EN
    return 5'((clear_left > 0) ? occ_frozen : live_count());
`else
    return 5'd0;
`endif
  endfunction

  always @(negedge clk) begin
    bit    exp_ready;
    beat_t inb;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      m_mid      = '{v: 1'b0, last: 1'b0, op: 2'd0, key: 8'd0, val: 22'd0};
      o_v        = 1'b0;
      o_last     = 1'b0;
      o_data     = '0;
      clear_left = 0;
      occ_frozen = 0;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_last_o", last_o, 0);
      chk("rst_read_data_o", read_data_o, 0);
      chk("rst_occupancy_o", occupancy_o, 0);
    end else begin
      exp_ready = (clear_left == 0) ? ready_i : 1'b0;
      chk("ready_o", ready_o, exp_ready);
      chk("valid_o", valid_o, o_v);
      if (o_v) begin
        chk("last_o", last_o, o_last);
        chk("read_data_o", read_data_o, o_data);
      end
      chk("occupancy_o", occupancy_o, exp_occ());
      if (o_v && exp_ready) got_q.push_back(read_data_o);
      if (exp_ready) begin
        exec(m_mid);
        inb.v    = valid_i;
        inb.last = last_i;
        inb.op   = valid_i ? data_in[31:30] : 2'd0;
        inb.key  = data_in[29:22];
        inb.val  = data_in[21:0];
        m_mid    = inb;
      end
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      end else if (flush_i) begin
        clear_left = DEPTH;
        occ_frozen = live_count();
      end
    end
  end

  task automatic step(input bit v, input logic [1:0] op, input logic [7:0] key,
                      input logic [21:0] val, input bit last);
    @(posedge clk);
    #1;
    valid_i = v;
    data_in = {op, key, val};
    last_i  = last;
    flush_i = 1'b0;
  endtask

  task automatic rand_step();
    @(posedge clk);
    #1;
    ready_i = ($urandom % 4) != 0;
    valid_i = ($urandom % 3) != 0;
    last_i  = $urandom % 2;
    flush_i = ($urandom % 120) == 0;
    data_in = {2'($urandom % 4), 4'($urandom % 6), 4'($urandom % 6), 22'($urandom)};
  endtask

  logic [31:0] exp_got [15];

  initial begin
    int n;
    reset   = 1'b0;
    data_in = '0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    got_q.delete();

    step(1, 2'd2, 8'h12, 22'h5, 0);
    step(0, 2'd0, 8'h00, 22'h0, 0);
    chk("latency_early", valid_o, 0);
    step(1, 2'd1, 8'h12, 22'h0, 0);
    chk("latency_valid", valid_o, 1);
    step(1, 2'd2, 8'h21, 22'h7, 0);
    step(1, 2'd1, 8'h21, 22'h0, 0);
    step(1, 2'd2, 8'h12, 22'h9, 0);
    step(1, 2'd3, 8'h12, 22'h0, 0);
    step(1, 2'd1, 8'h12, 22'h0, 1);
    step(1, 2'd2, 8'h33, 22'h2AAAA, 0);
    step(1, 2'd2, 8'h44, 22'h15555, 1);
    @(posedge clk);
    #1 valid_i = 1'b0;
    ready_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 ready_i = 1'b1;
    repeat (3) step(0, 2'd0, 8'h00, 22'h0, 0);
    step(1, 2'd2, 8'h01, 22'h1, 0);
    step(1, 2'd2, 8'h02, 22'h2, 0);
    step(1, 2'd2, 8'h03, 22'h3, 0);
    repeat (4) step(0, 2'd0, 8'h00, 22'h0, 0);
`ifdef HASH_TABLE_PIPE_STATS_EN
    chk("occ_before_flush", occupancy_o, 4);
`endif
    @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    n = 0;
    while (ready_o == 1'b0 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("flush_cycles", n, 16);
    step(1, 2'd1, 8'h01, 22'h0, 0);
    step(1, 2'd1, 8'h02, 22'h0, 0);
    step(1, 2'd1, 8'h03, 22'h0, 1);
    repeat (4) step(0, 2'd0, 8'h00, 22'h0, 0);
    chk("occ_after_flush", occupancy_o, 0);

    exp_got[0]  = pack(2'd1, 8'h12, 22'h5);
    exp_got[1]  = pack(2'd1, 8'h12, 22'h5);
    exp_got[2]  = pack(2'd3, 8'h21, 22'h5);
    exp_got[3]  = pack(2'd2, 8'h21, 22'h0);
    exp_got[4]  = pack(2'd1, 8'h12, 22'h9);
    exp_got[5]  = pack(2'd1, 8'h12, 22'h9);
    exp_got[6]  = pack(2'd2, 8'h12, 22'h0);
    exp_got[7]  = pack(2'd1, 8'h33, 22'h2AAAA);
    exp_got[8]  = pack(2'd3, 8'h44, 22'h2AAAA);
    exp_got[9]  = pack(2'd1, 8'h01, 22'h1);
    exp_got[10] = pack(2'd1, 8'h02, 22'h2);
    exp_got[11] = pack(2'd1, 8'h03, 22'h3);
    exp_got[12] = pack(2'd2, 8'h01, 22'h0);
    exp_got[13] = pack(2'd2, 8'h02, 22'h0);
    exp_got[14] = pack(2'd2, 8'h03, 22'h0);
    chk("directed_count", got_q.size(), 15);
    for (int i = 0; i < 15 && i < got_q.size(); i++) chk($sformatf("directed_beat%0d", i), got_q[i], exp_got[i]);

    repeat (3000) rand_step();

    repeat (6) begin
      @(posedge clk);
      #1 ready_i = 1'b1;
      valid_i = 1'b1;
      flush_i = 1'b0;
      data_in = {2'd2, 8'($urandom), 22'($urandom)};
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_valid_o", valid_o, 0);
    chk("async_rst_last_o", last_o, 0);
    chk("async_rst_read_data_o", read_data_o, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    valid_i = 1'b0;
    got_q.delete();
    for (int k = 0; k < DEPTH; k++) step(1, 2'd1, 8'(k), 22'h0, k == DEPTH - 1);
    repeat (4) step(0, 2'd0, 8'h00, 22'h0, 0);
    chk("post_reset_count", got_q.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < got_q.size(); k++)
      chk($sformatf("post_reset_miss%0d", k), got_q[k], pack(2'd2, 8'(k), 22'h0));

    repeat (400) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
